// File: rtl/sevens_format_if.sv
// Value/segment bus between a producer of display values and the sevens_format encoder.
interface sevens_format_if #(
    parameter int unsigned WIDTH = 27
);
    logic [WIDTH-1:0] value;
    logic             value_valid;
    logic             value_ready;
    logic             hex;
    logic             blank;
    logic [7:0]       dp;
    logic [7:0]       segments [8];

    modport master (
        output value, value_valid, hex, blank, dp,
        input  value_ready, segments
    );

    modport slave (
        input  value, value_valid, hex, blank, dp,
        output value_ready, segments
    );
endinterface

// File: rtl/sevens_format.sv
// Converts a binary value to eight seven-segment patterns (decimal via double-dabble, or hex)
// and holds them stable for the display scanner until the next accepted value.
module sevens_format #(
    parameter int unsigned WIDTH = 27
) (
    input  logic           clk,
    input  logic           reset,
    sevens_format_if.slave bus
);
    localparam int unsigned BCD_W   = 32;
    localparam int unsigned SR_W    = BCD_W + WIDTH;
    localparam int unsigned CNT_W   = $clog2(WIDTH);
    localparam int unsigned DEC_MAX = 99_999_999;

    typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic             ovf;
    logic             blank_q;
    logic [7:0]       dp_q;
    logic             leading;
    logic [7:0]       seg_next [8];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    assign bus.value_ready = (state == IDLE) && !reset;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        sr_adj = sr;
        for (int k = 0; k < 8; k++) begin
            if (sr[WIDTH + 4*k +: 4] >= 4'd5)
                sr_adj[WIDTH + 4*k +: 4] = sr[WIDTH + 4*k +: 4] + 4'd3;
        end
    end

    // Walk from the top digit down; leading stays set until the first nonzero digit.
    always_comb begin
        leading = blank_q;
        for (int i = 0; i < 8; i++) seg_next[i] = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            logic [3:0] d;
            logic [7:0] p;
            d = sr[WIDTH + 4*i +: 4];
            p = {1'b0, seg7(d)};
            if (d != 4'd0) leading = 1'b0;
            if (leading && i != 0) p = 8'h00;
            if (ovf) p = 8'h40;
            p[7] = dp_q[i];
            seg_next[i] = p;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            ovf     <= 1'b0;
            blank_q <= 1'b0;
            dp_q    <= 8'h00;
            for (int i = 0; i < 8; i++) bus.segments[i] <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.value_valid) begin
                        blank_q <= bus.blank;
                        dp_q    <= bus.dp;
                        if (bus.hex) begin
                            sr    <= {32'(bus.value), WIDTH'(0)};
                            ovf   <= 1'b0;
                            state <= ENCODE;
                        end else if (32'(bus.value) > 32'(DEC_MAX)) begin
                            ovf   <= 1'b1;
                            state <= ENCODE;
                        end else begin
                            sr    <= {BCD_W'(0), bus.value};
                            ovf   <= 1'b0;
                            cnt   <= '0;
                            state <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    sr <= {sr_adj[SR_W-2:0], 1'b0};
                    if (cnt == CNT_W'(WIDTH - 1)) state <= ENCODE;
                    else                          cnt   <= cnt + CNT_W'(1);
                end
                ENCODE: begin
                    for (int i = 0; i < 8; i++) bus.segments[i] <= seg_next[i];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
